// File: rtl/multdiv_unit_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide engine.
// Operation encoding, iteration count, request bundle, arithmetic helpers.
package multdiv_unit_pkg;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    M_MULT  = 2'd0,
    M_MULTU = 2'd1,
    M_DIV   = 2'd2,
    M_DIVU  = 2'd3
  } multicycle_t;

  typedef struct packed {
    multicycle_t op;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  function automatic logic is_div(
    input multicycle_t t
  );
    return (t == M_DIV) || (t == M_DIVU);
  endfunction

  function automatic logic is_sgn(
    input multicycle_t t
  );
    return (t == M_MULT) || (t == M_DIV);
  endfunction

  function automatic logic [31:0] abs32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

  // Full 64-bit product; signed operands are
  // sign-extended so the low 64 bits are exact.
  function automatic logic [63:0] mul64(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        sgn
  );
    logic [63:0] xe;
    logic [63:0] ye;
    xe = sgn ? {{32{x[31]}}, x} : {32'b0, x};
    ye = sgn ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

endpackage

// File: rtl/div_core_radix2.sv
// Unsigned 32/32 radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk, reset, start, abort, dividend, divisor, busy, done, quot, rem.
module div_core_radix2
  import multdiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam logic [5:0] LAST = 6'(DIV_ITERS - 1);

  logic [31:0] dvsr;
  logic [5:0]  cnt;

  logic [31:0] cur_rem;
  logic [31:0] cur_quot;
  logic [31:0] cur_dvsr;
  logic [32:0] tmp;
  logic        ge;
  logic [31:0] sub;
  logic [31:0] rem_nxt;
  logic [31:0] quot_nxt;

  // The first iteration runs on the start edge
  // straight from the operand inputs.
  always_comb begin
    cur_rem  = start ? 32'b0 : rem;
    cur_quot = start ? dividend : quot;
    cur_dvsr = start ? divisor : dvsr;
    tmp      = {cur_rem, cur_quot[31]};
    ge       = tmp >= {1'b0, cur_dvsr};
    // true difference is < 2^32 whenever ge
    sub      = tmp[31:0] - cur_dvsr;
    rem_nxt  = ge ? sub : tmp[31:0];
    quot_nxt = {cur_quot[30:0], ge};
  end

  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem  <= '0;
      quot <= '0;
      dvsr <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start || busy) begin
      rem  <= rem_nxt;
      quot <= quot_nxt;
      dvsr <= cur_dvsr;
      cnt  <= start ? 6'd1 : cnt + 6'd1;
      busy <= start || !done;
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Execute-stage multi-cycle HI/LO engine: MULT/MULTU/DIV/DIVU, one op at a time.
// Ports: clk, reset, valid_in/ready_out, mtype, a, b, flush, out_valid/out_ready, hi, lo.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [1:0]  mtype,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  localparam bit MUL_NOW = (MUL_LATENCY <= 1);
  localparam logic [7:0] MUL_LAST =
    8'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

  state_t      state;
  state_t      nxt;
  md_req_t     req;
  logic [7:0]  cnt;

  multicycle_t in_op;
  logic        accept;
  logic        in_div;
  logic        in_zero;
  logic        in_sgn;

  logic        core_start;
  logic        core_busy;
  logic        core_done;
  logic [31:0] core_quot;
  logic [31:0] core_rem;

  logic        q_neg;
  logic        r_neg;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  logic        load_zero;
  logic        load_now;
  logic        load_mul;
  logic        load_fix;

  assign ready_out = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign in_op   = multicycle_t'(mtype);
  assign accept  = valid_in && ready_out && !flush;
  assign in_div  = is_div(in_op);
  assign in_zero = (b == 32'b0);
  assign in_sgn  = is_sgn(in_op);

  assign core_start = accept && in_div && !in_zero;

  div_core_radix2 u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (core_start),
    .abort    (flush),
    .dividend (abs32(a, in_sgn)),
    .divisor  (abs32(b, in_sgn)),
    .busy     (core_busy),
    .done     (core_done),
    .quot     (core_quot),
    .rem      (core_rem)
  );

  // Quotient truncates toward zero; the
  // remainder follows the dividend's sign.
  assign q_neg = is_sgn(req.op) && (req.a[31] ^ req.b[31]);
  assign r_neg = is_sgn(req.op) && req.a[31];
  assign q_fix = q_neg ? -core_quot : core_quot;
  assign r_fix = r_neg ? -core_rem : core_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_div)       nxt = in_zero ? S_DONE : S_DIV;
          else if (MUL_NOW) nxt = S_DONE;
          else              nxt = S_MUL;
        end
      end
      S_MUL:  if (cnt == MUL_LAST) nxt = S_DONE;
      S_DIV: begin
        if (core_done)      nxt = S_FIX;
        else if (!core_busy) nxt = S_IDLE;
      end
      S_FIX:  nxt = S_DONE;
      S_DONE: if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (flush) nxt = S_IDLE;
  end

  assign load_zero = accept && in_div && in_zero;
  assign load_now  = accept && !in_div && MUL_NOW;
  assign load_mul  = (state == S_MUL) && !flush &&
                     (cnt == MUL_LAST);
  assign load_fix  = (state == S_FIX) && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req <= '0;
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (accept) begin
        req <= '{op: in_op, a: a, b: b};
        cnt <= '0;
      end else if (state == S_MUL) begin
        cnt <= cnt + 8'd1;
      end
      unique case (1'b1)
        load_zero: begin
          hi <= a;
          lo <= '1;
        end
        load_now: {hi, lo} <= mul64(a, b, in_sgn);
        load_mul: {hi, lo} <= mul64(req.a, req.b, is_sgn(req.op));
        load_fix: begin
          hi <= r_fix;
          lo <= q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus random ops
// against an arithmetic reference model.
module tb_multdiv_unit;
  import multdiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  mtype;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  multdiv_unit #(.MUL_LATENCY(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .mtype     (mtype),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // {hi, lo} from plain arithmetic
  function automatic logic [63:0] model(
    input logic [1:0]  mt,
    input logic [31:0] x,
    input logic [31:0] y
  );
    longint sx;
    longint sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (mt)
      M_MULT:  return 64'(sx * sy);
      M_MULTU: return {32'b0, x} * {32'b0, y};
      M_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic int exp_lat(
    input logic [1:0]  mt,
    input logic [31:0] y
  );
    if (mt == M_MULT || mt == M_MULTU) return 3;
    return (y == 0) ? 1 : 33;
  endfunction

  task automatic run_op(
    input logic [1:0]  mt,
    input logic [31:0] xa,
    input logic [31:0] xb,
    input int          hold
  );
    logic [63:0] exp;
    int cyc;
    exp = model(mt, xa, xb);
    valid_in = 1'b1;
    mtype = mt;
    a = xa;
    b = xb;
    @(posedge clk); #1;
    valid_in = 1'b0;
    a = $urandom;
    b = $urandom;
    mtype = 2'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(exp_lat(mt, xb)));
    check("hi", 64'(hi), 64'(exp[63:32]));
    check("lo", 64'(lo), 64'(exp[31:0]));
    check("busy_rdy", 64'(ready_out), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_vld", 64'(out_valid), 64'd1);
      check("hold_res", {hi, lo}, exp);
      check("hold_rdy", 64'(ready_out), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_vld", 64'(out_valid), 64'd0);
    check("drain_rdy", 64'(ready_out), 64'd1);
    check("idle_res", {hi, lo}, exp);
  endtask

  initial begin
    int seen;
    logic [1:0]  rt;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    valid_in = 1'b0;
    mtype = 2'd0;
    a = '0;
    b = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 64'(ready_out), 64'd1);
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(M_MULT,  32'hFFFF_FFFF, 32'd2, 0);
    run_op(M_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(M_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    run_op(M_DIVU,  32'd100, 32'd7, 0);
    run_op(M_DIV,   32'h0000_1234, 32'd0, 0);
    run_op(M_DIVU,  32'h0000_1234, 32'd0, 0);
    run_op(M_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(M_DIV,   32'd7, 32'hFFFF_FFFE, 1);

    // flush mid-divide
    valid_in = 1'b1;
    mtype = M_DIV;
    a = 32'd1000;
    b = 32'd3;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_rdy", 64'(ready_out), 64'd1);
    check("flush_vld", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_quiet", 64'(seen), 64'd0);
    run_op(M_MULTU, 32'd3, 32'd5, 0);

    // flush together with a request
    valid_in = 1'b1;
    flush = 1'b1;
    mtype = M_MULT;
    a = 32'd9;
    b = 32'd9;
    @(posedge clk); #1;
    valid_in = 1'b0;
    flush = 1'b0;
    check("flush_acc_rdy", 64'(ready_out), 64'd1);
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_acc_vld", 64'(seen), 64'd0);

    // consumer stalls in DONE
    run_op(M_DIVU, 32'hDEAD_BEEF, 32'd13, 5);

    // asynchronous reset mid-divide
    valid_in = 1'b1;
    mtype = M_DIVU;
    a = 32'd500;
    b = 32'd9;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_vld", 64'(out_valid), 64'd0);
    check("arst_rdy", 64'(ready_out), 64'd1);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(M_DIV, 32'hFFFF_FF00, 32'd7, 0);

    for (int i = 0; i < 30; i++) begin
      rt = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) rb = -rb;
      run_op(rt, ra, rb, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
